// File: rtl/zstd_pkg.sv
// Shared types and constants for the Zstandard block-level decoder.
package zstd_pkg;

  typedef enum logic [1:0] {
    BT_RAW  = 2'd0,
    BT_RLE  = 2'd1,
    BT_CMP  = 2'd2,
    BT_RSVD = 2'd3
  } block_type_e;

  localparam int BLOCK_HDR_BYTES        = 3;
  localparam int CHECKSUM_BYTES         = 4;
  localparam int DEFAULT_MAX_BLOCK_SIZE = 131072;

  // Bit layout of the 24-bit little-endian block header.
  typedef struct packed {
    logic [20:0] size;
    block_type_e btype;
    logic        last;
  } hdr_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHK,
    ST_RAW,
    ST_CMP,
    ST_RLE_B,
    ST_RLE_E,
    ST_NEXT,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/zstd_byte_unpacker.sv
// 16-bit word to byte unpacker with a 4-byte buffer; bytes visible the cycle after push.
// Caller only pushes with >= 2 free slots; flush discards contents and may seed one byte.
module zstd_byte_unpacker (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        load_vld,
  input  logic [7:0]  load_dat,
  input  logic        word_vld,
  input  logic [15:0] word_dat,
  input  logic        pop,
  output logic        byte_vld,
  output logic [7:0]  byte_dat,
  output logic [2:0]  cnt
);

  logic [3:0][7:0] mem_q, mem_d;
  logic [2:0]      cnt_q, cnt_d, base;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    base  = cnt_q;
    if (flush) begin
      mem_d    = '0;
      mem_d[0] = load_dat;
      cnt_d    = load_vld ? 3'd1 : 3'd0;
    end else begin
      if (pop && cnt_q != 3'd0) begin
        mem_d = {8'h00, mem_q[3:1]};
        base  = cnt_q - 3'd1;
      end
      cnt_d = base;
      // Earlier byte of the word lands first, right after whatever survives the pop.
      if (word_vld && base <= 3'd2) begin
        for (int i = 0; i < 4; i++) begin
          if (3'(i) == base)         mem_d[i] = word_dat[7:0];
          if (3'(i) == base + 3'd1)  mem_d[i] = word_dat[15:8];
        end
        cnt_d = base + 3'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign byte_vld = (cnt_q != 3'd0);
  assign byte_dat = mem_q[0];
  assign cnt      = cnt_q;

endmodule

// File: rtl/zstd_block_parser.sv
// Decodes Zstandard block headers and emits Raw/RLE/Compressed payload bytes, then the checksum.
// Header to first payload byte >= 2 cycles; 1 byte/cycle; out_valid holds until out_ready.
module zstd_block_parser
  import zstd_pkg::*;
#(
  parameter int MAX_BLOCK_SIZE = DEFAULT_MAX_BLOCK_SIZE,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             extra_valid,
  input  logic [7:0]       extra_byte,
  input  logic             checksum_flag,
  input  logic [15:0]      data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_block_type,
  output logic             out_last,
  output logic             hdr_valid,
  output logic             last_block,
  output logic [1:0]       block_type,
  output logic [20:0]      block_size,
  output logic [CNT_W-1:0] block_count,
  output logic [31:0]      checksum,
  output logic             finished,
  output logic             error
);

  localparam logic [20:0] MAX_SZ = 21'(MAX_BLOCK_SIZE);

  state_e      state_q, state_d;
  logic        u_byte_vld;
  logic [7:0]  u_byte_dat;
  logic [2:0]  u_cnt;
  logic        active, word_vld, pop;
  logic        hdr_done, rem_ld, rem_dec, rle_ld, csum_sh;
  logic [1:0]  hdr_idx_q, csum_idx_q;
  logic [7:0]  h0_q, h1_q, rle_q;
  logic [20:0] rem_q;
  logic        csum_flag_q;
  hdr_t        hdr_w;

  assign active   = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign in_ready = active && (u_cnt <= 3'd2) && !start;
  assign word_vld = in_valid && in_ready;
  assign hdr_w    = hdr_t'({u_byte_dat, h1_q, h0_q});
  assign finished = (state_q == ST_DONE);
  assign error    = (state_q == ST_ERR);

  zstd_byte_unpacker u_unpack (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (start),
    .load_vld (extra_valid),
    .load_dat (extra_byte),
    .word_vld (word_vld),
    .word_dat (data_in),
    .pop      (pop),
    .byte_vld (u_byte_vld),
    .byte_dat (u_byte_dat),
    .cnt      (u_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    out_valid      = 1'b0;
    out_byte       = 8'h00;
    out_last       = 1'b0;
    out_block_type = 2'd0;
    hdr_done       = 1'b0;
    rem_ld         = 1'b0;
    rem_dec        = 1'b0;
    rle_ld         = 1'b0;
    csum_sh        = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (u_byte_vld) begin
          pop = 1'b1;
          if (hdr_idx_q == 2'(BLOCK_HDR_BYTES - 1)) begin
            hdr_done = 1'b1;
            state_d  = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (block_type == BT_RSVD || block_size > MAX_SZ) state_d = ST_ERR;
        else if (block_type == BT_RLE)                   state_d = ST_RLE_B;
        else if (block_size == 21'd0)                    state_d = ST_NEXT;
        else begin
          rem_ld  = 1'b1;
          state_d = (block_type == BT_CMP) ? ST_CMP : ST_RAW;
        end
      end
      ST_RAW, ST_CMP: begin
        out_valid      = u_byte_vld;
        out_byte       = u_byte_dat;
        out_last       = (rem_q == 21'd1);
        out_block_type = block_type;
        if (u_byte_vld && out_ready) begin
          pop     = 1'b1;
          rem_dec = 1'b1;
          if (rem_q == 21'd1) state_d = ST_NEXT;
        end
      end
      ST_RLE_B: begin
        if (u_byte_vld) begin
          pop     = 1'b1;
          rle_ld  = 1'b1;
          rem_ld  = 1'b1;
          state_d = (block_size == 21'd0) ? ST_NEXT : ST_RLE_E;
        end
      end
      ST_RLE_E: begin
        out_valid      = 1'b1;
        out_byte       = rle_q;
        out_last       = (rem_q == 21'd1);
        out_block_type = block_type;
        if (out_ready) begin
          rem_dec = 1'b1;
          if (rem_q == 21'd1) state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (!last_block)      state_d = ST_HDR;
        else if (csum_flag_q) state_d = ST_CSUM;
        else                  state_d = ST_DONE;
      end
      ST_CSUM: begin
        if (u_byte_vld) begin
          pop     = 1'b1;
          csum_sh = 1'b1;
          if (csum_idx_q == 2'(CHECKSUM_BYTES - 1)) state_d = ST_DONE;
        end
      end
      default: ;
    endcase
    if (start) state_d = ST_HDR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_valid   <= 1'b0;
      last_block  <= 1'b0;
      block_type  <= 2'd0;
      block_size  <= 21'd0;
      block_count <= '0;
      checksum    <= 32'd0;
      csum_flag_q <= 1'b0;
      hdr_idx_q   <= 2'd0;
      csum_idx_q  <= 2'd0;
      h0_q        <= 8'h00;
      h1_q        <= 8'h00;
      rle_q       <= 8'h00;
      rem_q       <= 21'd0;
    end else begin
      hdr_valid <= 1'b0;
      if (start) begin
        last_block  <= 1'b0;
        block_type  <= 2'd0;
        block_size  <= 21'd0;
        block_count <= '0;
        checksum    <= 32'd0;
        csum_flag_q <= checksum_flag;
        hdr_idx_q   <= 2'd0;
        csum_idx_q  <= 2'd0;
      end else begin
        if (state_q == ST_HDR && pop) begin
          h1_q      <= u_byte_dat;
          h0_q      <= h1_q;
          hdr_idx_q <= hdr_done ? 2'd0 : hdr_idx_q + 2'd1;
        end
        if (hdr_done) begin
          hdr_valid  <= 1'b1;
          last_block <= hdr_w.last;
          block_type <= hdr_w.btype;
          block_size <= hdr_w.size;
          if (block_count != {CNT_W{1'b1}}) block_count <= block_count + CNT_W'(1);
        end
        if (rem_ld)       rem_q <= block_size;
        else if (rem_dec) rem_q <= rem_q - 21'd1;
        if (rle_ld) rle_q <= u_byte_dat;
        // First checksum byte is least significant, so shift in from the top.
        if (csum_sh) begin
          checksum   <= {u_byte_dat, checksum[31:8]};
          csum_idx_q <= csum_idx_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: doc/zstd_block_parser.md
Name: zstd_block_parser

Overview:
- Downstream neighbour of Header_Parser in the Zstandard decompressor.
- After the frame header is parsed, consumes the remaining 16-bit frame stream and decodes each 3-byte block header (Last_Block, Block_Type, Block_Size).
- Emits block payload as a byte stream: Raw passed through, RLE expanded, Compressed forwarded tagged for the literals/sequences stage.
- Consumes the optional 4-byte content checksum after the last block, then raises finished.

Parameters:
- MAX_BLOCK_SIZE, 131072, largest legal Block_Size; anything larger is an error.
- CNT_W, 16, width of block_count.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin a frame (same cycle Header_Parser asserts finished)
- extra_valid  in  1  sampled with start; extra_byte is the first stream byte
- extra_byte  in  8  leftover byte from Header_Parser
- checksum_flag  in  1  Frame_Header_Descriptor bit 2, sampled with start
- data_in  in  16  stream word; bits [7:0] are the earlier byte
- in_valid  in  1  data_in valid
- in_ready  out  1  word accepted when in_valid && in_ready
- out_byte  out  8  payload byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  downstream accepts byte
- out_block_type  out  2  type of the block out_byte belongs to
- out_last  out  1  last byte of the current block
- hdr_valid  out  1  one-cycle pulse when a block header is decoded
- last_block  out  1  header field, held until the next header
- block_type  out  2  header field, held until the next header
- block_size  out  21  header field, held until the next header
- block_count  out  CNT_W  headers decoded in this frame
- checksum  out  32  little-endian content checksum
- finished  out  1  level; frame complete
- error  out  1  level; sticky until start or reset

Behaviour:
- Reset values:
  - Every output 0.
  - in_ready 0.
  - FSM in IDLE; byte buffer empty.
- Byte unpacker: up to 4-byte buffer. in_ready = 1 when the FSM is not in IDLE/DONE/ERR and free space >= 2. On start with extra_valid, extra_byte is loaded first.
- States and transitions:
  - IDLE: wait for start. On start: clear block_count, finished, error, checksum; latch checksum_flag.
  - HDR (3 bytes): h = {b2,b1,b0}; last = h[0], type = h[2:1], size = h[23:3]. Pulse hdr_valid and increment block_count the cycle after the 3rd byte.
  - Header checks:
    - type 3 → ERR.
    - size > MAX_BLOCK_SIZE → ERR.
    - type 0 → RAW; type 2 → CMP; type 1 → RLE_B.
  - RAW / CMP: move size bytes buffer→out, one per cycle when out_ready; out_last on the final byte. size 0 → skip directly to NEXT, no output.
  - RLE_B: consume one byte, latch it → RLE_E. RLE_E: emit the latched byte size times; size 0 emits nothing.
  - NEXT:
    - last_block = 0 → HDR.
    - last_block = 1 and checksum_flag = 1 → CSUM (4 bytes, little-endian into checksum).
    - Otherwise → DONE.
  - DONE: finished = 1; any odd trailing byte in the buffer is discarded; stay until start.
  - ERR: error = 1, finished = 0, in_ready = 0, out_valid = 0; stay until start.
- Handshake and latency:
  - out_valid holds with stable out_byte/out_block_type/out_last until out_ready.
  - Throughput 1 byte/cycle; the first payload byte appears no earlier than 1 cycle after hdr_valid.
- Counter width: block_count saturates at all-ones.
- Simultaneous events:
  - start while active: restart as from IDLE; buffer flushed, fields cleared.
  - reset_n low at any time: immediate return to reset values.

Decomposition:
- Package zstd_pkg: block_type_e (BT_RAW=0, BT_RLE=1, BT_CMP=2, BT_RSVD=3), BLOCK_HDR_BYTES=3, CHECKSUM_BYTES=4, DEFAULT_MAX_BLOCK_SIZE=131072.
- One sub-module, zstd_byte_unpacker: 16-bit word in, byte out, 4-byte buffer, flush input.

Test Plan:
- Raw, last, no checksum: extra_byte 0x29, words 0x0000, 0x2211, 0x4433, 0x0055 → hdr_valid with last=1 type=0 size=5; bytes 11 22 33 44 55, out_last on 55; finished=1, block_count=1.
- RLE: extra_byte 0x23, words 0x0000, 0x00AB → size=4 type=1; bytes AB AB AB AB then finished.
- Two blocks plus checksum:
  - Stimulus: checksum_flag=1, no extra byte; raw non-last size 2 (10 00 00 AA BB), raw-last size 0 (01 00 00), checksum bytes 78 56 34 12.
  - Response: bytes AA BB; block_count=2; checksum=0x12345678; finished=1.
- Errors, each with error=1, finished=0, in_ready=0:
  - Header byte 0x07 (type 3).
  - Header bytes 09 00 10 (size 131073).
- Backpressure: raw size 5 with out_ready toggling 1010… → bytes identical and in order, each held stable while out_ready=0.
- Reset mid-block: reset_n low during a RAW payload → all outputs 0 within the same cycle. A new start then parses a fresh frame correctly.
